// File: rtl/seg7_scan_decoder_if.sv
// Bundle of the multiplexed display bus (active-low anodes/segments) and the
// reconstructed digit readback produced by the scan decoder.
interface seg7_scan_decoder_if;
   logic [0:6]  SSeg;
   logic [3:0]  an;
   logic [19:0] codes;
   logic [3:0]  valid;
   logic        frame_done;
   logic        anode_err;
   logic        stale;

   modport master (
      output SSeg, an,
      input  codes, valid, frame_done, anode_err, stale
   );

   modport slave (
      input  SSeg, an,
      output codes, valid, frame_done, anode_err, stale
   );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Watches a multiplexed seven-segment scan and rebuilds the four displayed
// digits as 5-bit codes, with dwell filtering, anode checking and stall detection.
module seg7_scan_decoder #(
   parameter int STABLE  = 4,
   parameter int TIMEOUT = 1024
) (
   input logic                 clk2,
   input logic                 rst,
   seg7_scan_decoder_if.slave  bus
);

   localparam int DW = $clog2(STABLE + 1);
   localparam int IW = $clog2(TIMEOUT + 1);

   logic [10:0]   pairQ, pairD;
   logic [DW-1:0] dwellQ, dwellD;
   logic [19:0]   codesQ, codesD;
   logic [3:0]    validQ, validD;
   logic [3:0]    seenQ, seenD;
   logic          frameDoneQ, frameDoneD;
   logic          anodeErrQ, anodeErrD;
   logic [IW-1:0] idleQ, idleD;

   logic [10:0]   pairIn;
   logic          samePair;
   logic          captureEv;
   logic [3:0]    digitHit;
   logic          anodeIllegal;
   logic [4:0]    segCode;

   assign pairIn = {bus.an, bus.SSeg};

   // A cleared dwell count means the current pair has not been sampled yet,
   // so the first edge after reset always starts a fresh window.
   assign samePair  = (pairIn == pairQ) && (dwellQ != '0);
   assign captureEv = samePair && (dwellQ == DW'(STABLE - 1));

   always_comb begin
      digitHit     = 4'b0000;
      anodeIllegal = 1'b0;
      case (bus.an)
         4'b1110: digitHit = 4'b0001;
         4'b1101: digitHit = 4'b0010;
         4'b1011: digitHit = 4'b0100;
         4'b0111: digitHit = 4'b1000;
         4'b1111: anodeIllegal = 1'b0;
         default: anodeIllegal = 1'b1;
      endcase
   end

   always_comb begin
      segCode = 5'h1F;
      case (bus.SSeg)
         7'b0000001: segCode = 5'h00;
         7'b1001111: segCode = 5'h01;
         7'b0010010: segCode = 5'h02;
         7'b0000110: segCode = 5'h03;
         7'b1001100: segCode = 5'h04;
         7'b0100100: segCode = 5'h05;
         7'b0100000: segCode = 5'h06;
         7'b0001111: segCode = 5'h07;
         7'b0000000: segCode = 5'h08;
         7'b0000100: segCode = 5'h09;
         7'b0001000: segCode = 5'h0A;
         7'b1100000: segCode = 5'h0B;
         7'b0110001: segCode = 5'h0C;
         7'b1000010: segCode = 5'h0D;
         7'b0110000: segCode = 5'h0E;
         7'b0111000: segCode = 5'h0F;
         7'b1111111: segCode = 5'h10;
         7'b1111110: segCode = 5'h11;
         default:    segCode = 5'h1F;
      endcase
   end

   // The dwell count saturates at STABLE so a held pair fires exactly once;
   // a full seen mask is retired one edge later together with the frame pulse.
   always_comb begin
      pairD      = pairIn;
      dwellD     = 1;
      codesD     = codesQ;
      validD     = validQ;
      seenD      = (seenQ == 4'b1111) ? 4'b0000 : seenQ;
      frameDoneD = (seenQ == 4'b1111);
      anodeErrD  = 1'b0;
      idleD      = (idleQ == IW'(TIMEOUT)) ? idleQ : idleQ + IW'(1);

      if (samePair) begin
         dwellD = (dwellQ == DW'(STABLE)) ? dwellQ : dwellQ + DW'(1);
      end

      if (captureEv) begin
         if (digitHit != 4'b0000) begin
            for (int i = 0; i < 4; i++) begin
               if (digitHit[i]) begin
                  codesD[i*5 +: 5] = segCode;
                  validD[i]        = 1'b1;
                  seenD[i]         = 1'b1;
               end
            end
            idleD = '0;
         end else if (anodeIllegal) begin
            anodeErrD = 1'b1;
         end
      end
   end

   always_ff @(posedge clk2) begin
      if (rst) begin
         pairQ      <= '0;
         dwellQ     <= '0;
         codesQ     <= {4{5'h10}};
         validQ     <= 4'b0000;
         seenQ      <= 4'b0000;
         frameDoneQ <= 1'b0;
         anodeErrQ  <= 1'b0;
         idleQ      <= '0;
      end else begin
         pairQ      <= pairD;
         dwellQ     <= dwellD;
         codesQ     <= codesD;
         validQ     <= validD;
         seenQ      <= seenD;
         frameDoneQ <= frameDoneD;
         anodeErrQ  <= anodeErrD;
         idleQ      <= idleD;
      end
   end

   assign bus.codes      = codesQ;
   assign bus.valid      = validQ;
   assign bus.frame_done = frameDoneQ;
   assign bus.anode_err  = anodeErrQ;
   assign bus.stale      = (idleQ == IW'(TIMEOUT));

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: directed scans push expected readback
// events into a queue that a free-running monitor pops and compares.
module tb_seg7_scan_decoder;

   localparam logic [19:0] BLANK = 20'h84210;

   typedef struct packed {
      logic [19:0] codes;
      logic [3:0]  valid;
      logic        fd;
      logic        err;
   } evT;

   logic clk2 = 1'b0;
   logic rst  = 1'b1;
   int   compared   = 0;
   int   mismatched = 0;
   int   frameCount = 0;

   evT          expQ[$];
   logic [19:0] expCodes = BLANK;
   logic [3:0]  expValid = 4'b0000;

   seg7_scan_decoder_if bus ();

   seg7_scan_decoder #(.STABLE(4), .TIMEOUT(16)) dut (
      .clk2 (clk2),
      .rst  (rst),
      .bus  (bus)
   );

   always #5 clk2 = ~clk2;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Called at a falling edge; holds the pair for n rising edges and returns at a falling edge.
   task automatic applyStimulus(input logic [3:0] anV, input logic [6:0] segV, input int n);
      bus.an   = anV;
      bus.SSeg = segV;
      repeat (n) @(posedge clk2);
      @(negedge clk2);
   endtask

   task automatic expectCapture(input int slot, input logic [4:0] code);
      logic [19:0] c;
      logic [3:0]  v;
      evT          e;
      c = expCodes;
      v = expValid;
      c[slot*5 +: 5] = code;
      v[slot] = 1'b1;
      if (c !== expCodes || v !== expValid) begin
         expCodes = c;
         expValid = v;
         e.codes = c; e.valid = v; e.fd = 1'b0; e.err = 1'b0;
         expQ.push_back(e);
      end
   endtask

   task automatic expectFrame();
      evT e;
      e.codes = expCodes; e.valid = expValid; e.fd = 1'b1; e.err = 1'b0;
      expQ.push_back(e);
   endtask

   task automatic expectError();
      evT e;
      e.codes = expCodes; e.valid = expValid; e.fd = 1'b0; e.err = 1'b1;
      expQ.push_back(e);
   endtask

   task automatic doReset();
      rst = 1'b1;
      @(posedge clk2);
      @(negedge clk2);
      rst = 1'b0;
      expCodes = BLANK;
      expValid = 4'b0000;
      checkOutput("reset codes", 32'(bus.codes), 32'(BLANK));
      checkOutput("reset valid", 32'(bus.valid), 32'h0);
      checkOutput("reset frame_done", 32'(bus.frame_done), 32'h0);
      checkOutput("reset anode_err", 32'(bus.anode_err), 32'h0);
      checkOutput("reset stale", 32'(bus.stale), 32'h0);
   endtask

   // Monitor: any visible readback change or pulse is one event to be matched.
   initial begin
      logic [19:0] prevC;
      logic [3:0]  prevV;
      evT          e;
      evT          got;
      prevC = BLANK;
      prevV = 4'b0000;
      forever begin
         @(posedge clk2);
         #2;
         if (rst) begin
            prevC = bus.codes;
            prevV = bus.valid;
         end else if (bus.frame_done || bus.anode_err || bus.codes !== prevC || bus.valid !== prevV) begin
            got = {bus.codes, bus.valid, bus.frame_done, bus.anode_err};
            if (expQ.size() == 0) begin
               compared++;
               mismatched++;
               $display("[TB] FAIL unexpected event: got 0x%0h, expected none", got);
            end else begin
               e = expQ.pop_front();
               checkOutput("event", 32'(got), 32'(e));
            end
            if (bus.frame_done) frameCount++;
            prevC = bus.codes;
            prevV = bus.valid;
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bus.an   = 4'b1111;
      bus.SSeg = 7'b1111111;
      @(negedge clk2);
      doReset();

      // Single capture of digit 8 in slot 0, then a long hold with no re-fire.
      $display("[TB] single capture");
      expectCapture(0, 5'h08);
      applyStimulus(4'b1110, 7'b0000000, 4);
      checkOutput("slot0 after dwell", 32'(bus.codes[4:0]), 32'h08);
      checkOutput("valid after dwell", 32'(bus.valid), 32'h1);
      applyStimulus(4'b1110, 7'b0000000, 6);
      checkOutput("codes while held", 32'(bus.codes), 32'(expCodes));

      // Short dwell aborted, then a full one.
      $display("[TB] short dwell");
      applyStimulus(4'b1101, 7'b0010010, 3);
      applyStimulus(4'b1111, 7'b1111111, 2);
      checkOutput("slot1 after short dwell", 32'(bus.codes[9:5]), 32'h10);
      expectCapture(1, 5'h02);
      applyStimulus(4'b1101, 7'b0010010, 4);
      checkOutput("slot1 after full dwell", 32'(bus.codes[9:5]), 32'h02);

      // Full scan completing a frame, twice.
      $display("[TB] frame scans");
      expectCapture(0, 5'h01);
      applyStimulus(4'b1110, 7'b1001111, 5);
      expectCapture(1, 5'h11);
      applyStimulus(4'b1101, 7'b1111110, 5);
      expectCapture(2, 5'h10);
      applyStimulus(4'b1011, 7'b1111111, 5);
      expectCapture(3, 5'h06);
      expectFrame();
      applyStimulus(4'b0111, 7'b0100000, 5);
      checkOutput("scan codes", 32'(bus.codes), 32'({5'h06, 5'h10, 5'h11, 5'h01}));
      checkOutput("scan valid", 32'(bus.valid), 32'hF);
      checkOutput("frame count 1", 32'(frameCount), 32'd1);
      applyStimulus(4'b1110, 7'b1001111, 5);
      applyStimulus(4'b1101, 7'b1111110, 5);
      applyStimulus(4'b1011, 7'b1111111, 5);
      expectFrame();
      applyStimulus(4'b0111, 7'b0100000, 5);
      checkOutput("frame count 2", 32'(frameCount), 32'd2);

      // Illegal anode, idle hold, invalid segment pattern.
      $display("[TB] anode error and invalid segments");
      expectError();
      applyStimulus(4'b1100, 7'b0000000, 4);
      checkOutput("codes after anode error", 32'(bus.codes), 32'({5'h06, 5'h10, 5'h11, 5'h01}));
      applyStimulus(4'b1111, 7'b1111111, 6);
      expectCapture(2, 5'h1F);
      applyStimulus(4'b1011, 7'b1010101, 4);
      checkOutput("slot2 invalid", 32'(bus.codes[14:10]), 32'h1F);

      // Stall detection.
      $display("[TB] stale");
      applyStimulus(4'b1111, 7'b1111111, 1);
      doReset();
      applyStimulus(4'b1111, 7'b1111111, 15);
      checkOutput("stale at 15", 32'(bus.stale), 32'h0);
      applyStimulus(4'b1111, 7'b1111111, 1);
      checkOutput("stale at 16", 32'(bus.stale), 32'h1);
      applyStimulus(4'b1110, 7'b0000110, 3);
      checkOutput("stale mid dwell", 32'(bus.stale), 32'h1);
      expectCapture(0, 5'h03);
      applyStimulus(4'b1110, 7'b0000110, 1);
      checkOutput("stale after capture", 32'(bus.stale), 32'h0);

      // Reset on the third edge of a dwell.
      $display("[TB] reset mid dwell");
      applyStimulus(4'b0111, 7'b0001111, 2);
      doReset();
      applyStimulus(4'b0111, 7'b0001111, 3);
      checkOutput("valid 3 edges after reset", 32'(bus.valid), 32'h0);
      expectCapture(3, 5'h07);
      applyStimulus(4'b0111, 7'b0001111, 1);
      checkOutput("valid 4 edges after reset", 32'(bus.valid), 32'h8);
      checkOutput("slot3 after reset dwell", 32'(bus.codes[19:15]), 32'h07);

      applyStimulus(4'b1111, 7'b1111111, 4);
      checkOutput("queue drained", 32'(expQ.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
